rr_arbiter8: RTL

Round-robin arbiter that shares one resource between eight requesters and presents the winner both as a one-hot grant vector and as a 3-bit encoded index. It sits in front of any shared 8-way datapath (bus port, encoder-driven mux, shared register file port) and sequences ownership with a request/done handshake. A hold-time limit forces release, so a stuck requester cannot starve the others.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick8.sv | 42 ++++
 rtl/rr_arbiter8.sv | 92 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   N_REQ       : number of requesters
//   IDX_W       : width of the encoded grant index
//   arb_state_e : arbiter FSM states
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick among 8 requesters.
//   i_req    : request vector
//   i_ptr    : index with highest priority this round
//   o_onehot : one-hot winner (all-zero when no request)
//   o_idx    : binary index of the winner (0 when no request)
//   o_any    : at least one request present
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [2*N_REQ-1:0] w_rot_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]   w_ridx;
  logic [N_REQ-1:0]   w_rot_oh;
  logic [2*N_REQ-1:0] w_back_dbl;

  always_comb begin
    // Rotate right by ptr so the pointer position lands on bit 0.
    w_rot_dbl = {i_req, i_req} >> i_ptr;
    w_rot     = w_rot_dbl[N_REQ-1:0];
    o_any     = |w_rot;

    // LSB-first fixed priority: scanning downward leaves the lowest set bit.
    w_ridx = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (w_rot[i]) w_ridx = IDX_W'(i);
    end
    w_rot_oh = o_any ? (N_REQ'(1) << w_ridx) : '0;

    // Rotate the winner back left by ptr into requester numbering.
    w_back_dbl = {w_rot_oh, w_rot_oh} << i_ptr;
    o_onehot   = w_back_dbl[2*N_REQ-1:N_REQ];
    o_idx      = o_any ? (w_ridx + i_ptr) : '0;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter, 8 requesters, request/done handshake with hold limit.
//   clk, rst_n  : clock, async active-low reset
//   req         : per-requester level request
//   done        : owner releases the resource (only looked at while owned)
//   grant       : registered one-hot owner
//   grant_idx   : registered binary index of owner (0 when none)
//   grant_valid : an owner exists
//   timeout     : one-cycle pulse after a forced release by HOLD_MAX
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int HW = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX+1);
  localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX > 0) ? HOLD_MAX-1 : 0);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [HW-1:0]    r_hold;

  logic [N_REQ-1:0] w_oh;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_owner_req;
  logic             w_limit;
  logic             w_release;

  rr_pick8 u_pick (
    .i_req    (req),
    .i_ptr    (r_ptr),
    .o_onehot (w_oh),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // r_hold counts completed owned cycles; hitting HOLD_MAX-1 means the
  // current cycle is the last one allowed.
  assign w_owner_req = req[grant_idx];
  assign w_limit     = (HOLD_MAX != 0) && (r_hold == HOLD_LAST);
  assign w_release   = done || !w_owner_req || w_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= '0;
      r_hold      <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            grant       <= w_oh;
            grant_idx   <= w_idx;
            grant_valid <= 1'b1;
            r_hold      <= '0;
            r_state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (w_release) begin
            r_ptr       <= grant_idx + 3'd1;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            // done and withdraw both outrank the limit for reporting.
            timeout     <= !done && w_owner_req;
            r_state     <= ARB_IDLE;
          end else if (r_hold != HOLD_SAT) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
